// File: rtl/vga_scan_controller_if.sv
// Pixel-request, colour-return and DAC pin bundle between the scan controller and its
// pixel generator / video DAC.
interface vga_scan_controller_if;
   logic [9:0] vga_x;
   logic [8:0] vga_y;
   logic       request;
   logic       frame_start;
   logic [7:0] pix_r;
   logic [7:0] pix_g;
   logic [7:0] pix_b;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;
   logic       vga_hs;
   logic       vga_vs;
   logic       vga_blank_n;
   logic       vga_sync_n;

   modport master (
      output vga_x, vga_y, request, frame_start,
      output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
      input  pix_r, pix_g, pix_b
   );

   modport slave (
      input  vga_x, vga_y, request, frame_start,
      input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
      output pix_r, pix_g, pix_b
   );
endinterface

// File: rtl/vga_scan_controller.sv
// VGA raster timing master: scans the frame, requests pixels, and re-times sync/blank
// so they line up with the colour returned PIX_LATENCY clocks after each request.
module vga_scan_controller #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int PIX_LATENCY = 1
) (
   input logic                   clk,
   input logic                   reset,
   vga_scan_controller_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

   // alignment word layout: {hs_n, vs_n, active}; idle = syncs released, blanked
   localparam logic [2:0] ALIGN_IDLE = 3'b110;

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       active;
   logic       hs_n;
   logic       vs_n;
   logic       hs_q;
   logic       vs_q;
   logic [2:0] align [PIX_LATENCY];
   logic [2:0] tap;

   always_comb begin
      active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_n   = !((h_cnt >= H_SYNC_ON) && (h_cnt < H_SYNC_OFF));
      vs_n   = !((v_cnt >= V_SYNC_ON) && (v_cnt < V_SYNC_OFF));
   end

   assign tap            = align[PIX_LATENCY-1];
   assign bus.vga_sync_n = 1'b0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.request     <= 1'b0;
         bus.vga_x       <= '0;
         bus.vga_y       <= '0;
         bus.frame_start <= 1'b0;
         hs_q            <= 1'b1;
         vs_q            <= 1'b1;
      end else begin
         bus.request     <= active;
         bus.vga_x       <= active ? h_cnt : '0;
         bus.vga_y       <= active ? v_cnt[8:0] : '0;
         bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
         hs_q            <= hs_n;
         vs_q            <= vs_n;
      end
   end

   // delays sync/blank by the pixel generator's latency
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PIX_LATENCY; i++) align[i] <= ALIGN_IDLE;
      end else begin
         align[0] <= {hs_q, vs_q, bus.request};
         for (int i = 1; i < PIX_LATENCY; i++) align[i] <= align[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.vga_hs      <= 1'b1;
         bus.vga_vs      <= 1'b1;
         bus.vga_blank_n <= 1'b0;
         bus.vga_r       <= '0;
         bus.vga_g       <= '0;
         bus.vga_b       <= '0;
      end else begin
         bus.vga_hs      <= tap[2];
         bus.vga_vs      <= tap[1];
         bus.vga_blank_n <= tap[0];
         bus.vga_r       <= tap[0] ? bus.pix_r : '0;
         bus.vga_g       <= tap[0] ? bus.pix_g : '0;
         bus.vga_b       <= tap[0] ? bus.pix_b : '0;
      end
   end
endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench: one full-width instance (short frame, latency 1) and one miniature
// raster (latency 3) checked for timing, alignment, blank gating and reset behaviour.
module tb_vga_scan_controller;
   logic clk = 1'b0;
   logic reset;
   logic force_ff;
   logic ff_q;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #20 clk = ~clk;

   vga_scan_controller_if if_a ();
   vga_scan_controller_if if_b ();

   vga_scan_controller #(
      .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LATENCY(1)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(if_a)
   );

   vga_scan_controller #(
      .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LATENCY(3)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(if_b)
   );

   // pixel generator model: colour derived from the request, delayed by the latency
   logic [7:0] xa, ya;
   logic [7:0] xb [3];
   logic [7:0] yb [3];

   always @(posedge clk) begin
      ff_q  <= force_ff;
      xa    <= if_a.vga_x[7:0];
      ya    <= if_a.vga_y[7:0];
      xb[0] <= if_b.vga_x[7:0];
      yb[0] <= if_b.vga_y[7:0];
      xb[1] <= xb[0];
      yb[1] <= yb[0];
      xb[2] <= xb[1];
      yb[2] <= yb[1];
   end

   assign if_a.pix_r = force_ff ? 8'hFF : xa;
   assign if_a.pix_g = force_ff ? 8'hFF : ya;
   assign if_a.pix_b = force_ff ? 8'hFF : (xa ^ 8'h5A);
   assign if_b.pix_r = force_ff ? 8'hFF : xb[2];
   assign if_b.pix_g = force_ff ? 8'hFF : yb[2];
   assign if_b.pix_b = force_ff ? 8'hFF : (xb[2] ^ 8'h5A);

   logic [9:0] m_x   [2];
   logic [8:0] m_y   [2];
   logic       m_req [2];
   logic       m_fs  [2];
   logic       m_hs  [2];
   logic       m_vs  [2];
   logic       m_bl  [2];
   logic       m_sn  [2];
   logic [7:0] m_r   [2];
   logic [7:0] m_g   [2];
   logic [7:0] m_b   [2];

   assign m_x[0] = if_a.vga_x;        assign m_x[1] = if_b.vga_x;
   assign m_y[0] = if_a.vga_y;        assign m_y[1] = if_b.vga_y;
   assign m_req[0] = if_a.request;    assign m_req[1] = if_b.request;
   assign m_fs[0] = if_a.frame_start; assign m_fs[1] = if_b.frame_start;
   assign m_hs[0] = if_a.vga_hs;      assign m_hs[1] = if_b.vga_hs;
   assign m_vs[0] = if_a.vga_vs;      assign m_vs[1] = if_b.vga_vs;
   assign m_bl[0] = if_a.vga_blank_n; assign m_bl[1] = if_b.vga_blank_n;
   assign m_sn[0] = if_a.vga_sync_n;  assign m_sn[1] = if_b.vga_sync_n;
   assign m_r[0] = if_a.vga_r;        assign m_r[1] = if_b.vga_r;
   assign m_g[0] = if_a.vga_g;        assign m_g[1] = if_b.vga_g;
   assign m_b[0] = if_a.vga_b;        assign m_b[1] = if_b.vga_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_idle(input int id, input string pfx);
      chk({pfx, "_r"}, 32'(m_r[id]), 0);
      chk({pfx, "_g"}, 32'(m_g[id]), 0);
      chk({pfx, "_b"}, 32'(m_b[id]), 0);
      chk({pfx, "_hs"}, 32'(m_hs[id]), 1);
      chk({pfx, "_vs"}, 32'(m_vs[id]), 1);
      chk({pfx, "_blank_n"}, 32'(m_bl[id]), 0);
      chk({pfx, "_sync_n"}, 32'(m_sn[id]), 0);
      chk({pfx, "_request"}, 32'(m_req[id]), 0);
      chk({pfx, "_frame_start"}, 32'(m_fs[id]), 0);
      chk({pfx, "_x"}, 32'(m_x[id]), 0);
      chk({pfx, "_y"}, 32'(m_y[id]), 0);
   endtask

   // t counts rising edges since reset release; sampled on the falling edge
   task automatic monitor(input int id, input string nm, input int n,
                          input int e_fs2, input int e_rq_fall, input int e_rq_rise2,
                          input int e_hs_fall, input int e_hs_low, input int e_hs_fall2,
                          input int e_vs_fall, input int e_vs_low,
                          input int e_bl_rise, input int e_max_y);
      int fs1 = -1, fs2 = -1, rq_r1 = -1, rq_f = -1, rq_r2 = -1;
      int hs_f1 = -1, hs_r1 = -1, hs_f2 = -1, vs_f = -1, vs_r = -1;
      int bl_r = -1, r_bl = -1, max_y = 0, col = 0, row = 0;
      logic p_rq = 1'b0, p_hs = 1'b1, p_vs = 1'b1, p_bl = 1'b0;
      logic [7:0] er, eg, eb;
      for (int t = 1; t <= n; t++) begin
         @(negedge clk);
         if (m_fs[id]) begin
            if (fs1 < 0) fs1 = t;
            else if (fs2 < 0) fs2 = t;
            row = 0;
         end
         if (!p_rq && m_req[id]) begin
            if (rq_r1 < 0) rq_r1 = t;
            else if (rq_r2 < 0) rq_r2 = t;
         end
         if (p_rq && !m_req[id] && rq_f < 0) rq_f = t;
         if (p_hs && !m_hs[id]) begin
            if (hs_f1 < 0) hs_f1 = t;
            else if (hs_f2 < 0) hs_f2 = t;
         end
         if (!p_hs && m_hs[id] && hs_r1 < 0) hs_r1 = t;
         if (p_vs && !m_vs[id] && vs_f < 0) vs_f = t;
         if (!p_vs && m_vs[id] && vs_r < 0) vs_r = t;
         if (!p_bl && m_bl[id] && bl_r < 0) begin
            bl_r = t;
            r_bl = int'(m_r[id]);
         end
         if (p_bl && !m_bl[id]) begin
            row++;
            col = 0;
         end
         if (int'(m_y[id]) > max_y) max_y = int'(m_y[id]);
         if (m_bl[id]) begin
            if (ff_q) begin
               er = 8'hFF; eg = 8'hFF; eb = 8'hFF;
            end else begin
               er = 8'(col); eg = 8'(row); eb = 8'(col) ^ 8'h5A;
            end
            col++;
         end else begin
            er = 8'h00; eg = 8'h00; eb = 8'h00;
         end
         chk({nm, "_pix_r"}, 32'(m_r[id]), 32'(er));
         chk({nm, "_pix_g"}, 32'(m_g[id]), 32'(eg));
         chk({nm, "_pix_b"}, 32'(m_b[id]), 32'(eb));
         p_rq = m_req[id];
         p_hs = m_hs[id];
         p_vs = m_vs[id];
         p_bl = m_bl[id];
         if (id == 0 && t == 8000) force_ff = 1'b1;
      end
      chk({nm, "_fs_first"}, fs1, 1);
      chk({nm, "_fs_second"}, fs2, e_fs2);
      chk({nm, "_req_rise"}, rq_r1, 1);
      chk({nm, "_req_fall"}, rq_f, e_rq_fall);
      chk({nm, "_req_rise2"}, rq_r2, e_rq_rise2);
      chk({nm, "_hs_fall"}, hs_f1, e_hs_fall);
      chk({nm, "_hs_low"}, hs_r1 - hs_f1, e_hs_low);
      chk({nm, "_hs_fall2"}, hs_f2, e_hs_fall2);
      chk({nm, "_vs_fall"}, vs_f, e_vs_fall);
      chk({nm, "_vs_low"}, vs_r - vs_f, e_vs_low);
      chk({nm, "_blank_rise"}, bl_r, e_bl_rise);
      chk({nm, "_first_pixel"}, r_bl, 0);
      chk({nm, "_max_y"}, max_y, e_max_y);
   endtask

   initial begin
      bit found;
      reset    = 1'b0;
      force_ff = 1'b1;
      repeat (3) @(negedge clk);
      check_idle(0, "rst_a");
      check_idle(1, "rst_b");

      reset    = 1'b1;
      force_ff = 1'b0;
      fork
         monitor(0, "a", 17800, 8801, 641, 801, 659, 96, 1459, 4803, 1600, 3, 3);
         monitor(1, "b", 17800, 456, 21, 36, 29, 6, 64, 285, 70, 5, 5);
      join

      found = 1'b0;
      for (int i = 0; i < 10000 && !found; i++) begin
         @(negedge clk);
         if (m_x[0] == 10'd300 && m_y[0] == 9'd2) found = 1'b1;
      end
      chk("find_300_2", 32'(found), 1);
      if (found) begin
         chk("pre_rst_blank_n", 32'(m_bl[0]), 1);
         #5 reset = 1'b0;
         #1 check_idle(0, "async_a");
         repeat (2) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         chk("restart_request", 32'(m_req[0]), 1);
         chk("restart_x", 32'(m_x[0]), 0);
         chk("restart_y", 32'(m_y[0]), 0);
         chk("restart_frame_start", 32'(m_fs[0]), 1);
         @(negedge clk);
         chk("restart_x_next", 32'(m_x[0]), 1);
         chk("restart_fs_next", 32'(m_fs[0]), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
